// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner issuing in-order ibus reads into a small instruction queue with redirect/flush
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH    = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        id_ready_i,
  input  logic        bp_isbranch_i,
  input  logic [31:0] bp_branch_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i
);
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int AW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int BW = CW + OW;

  logic [31:0]   pc;
  logic [QW-1:0] head, tail;
  logic [CW-1:0] qcount;
  logic [OW-1:0] outst, discard, outst_next, discard_next;
  logic [AW-1:0] a_wr, a_rd, a_wr_nx, a_rd_nx;
  logic [BW-1:0] used;
  logic [31:0]   q_addr [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [31:0]   a_fifo [MAX_OUTST];
  logic          empty, grant, deq, pred, push, flush;
  logic          unused_lsbs;

  assign unused_lsbs = ^{jump_addr_i[1:0], bp_branch_addr_i[1:0]};

  // Request budget, handshakes, redirect decode and the next outstanding/discard counts
  always_comb begin
    used         = BW'(qcount) + BW'(outst) - BW'(discard);
    empty        = qcount == '0;
    ibus_req_o   = rst && !jump_flag_i && outst < OW'(MAX_OUTST) && used < BW'(QDEPTH);
    ibus_addr_o  = pc;
    grant        = ibus_req_o && ibus_gnt_i;
    inst_valid_o = !empty && !jump_flag_i;
    inst_o       = empty ? INST_NOP : q_data[head];
    inst_addr_o  = empty ? 32'h0 : q_addr[head];
    deq          = inst_valid_o && id_ready_i;
    pred         = deq && bp_isbranch_i;
    flush        = jump_flag_i || pred;
    push         = ibus_rvalid_i && discard == '0 && !flush;
    outst_next   = outst + OW'(grant) - OW'(ibus_rvalid_i);
    discard_next = jump_flag_i ? outst - OW'(ibus_rvalid_i) :
                   pred ? outst_next :
                   (ibus_rvalid_i && discard != '0) ? discard - OW'(1) : discard;
    a_wr_nx      = a_wr == AW'(MAX_OUTST - 1) ? '0 : a_wr + AW'(1);
    a_rd_nx      = a_rd == AW'(MAX_OUTST - 1) ? '0 : a_rd + AW'(1);
  end

  // PC, queue pointers and bus bookkeeping; a redirect empties the queue outright
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      head    <= '0;
      tail    <= '0;
      qcount  <= '0;
      outst   <= '0;
      discard <= '0;
      a_wr    <= '0;
      a_rd    <= '0;
    end else begin
      pc      <= jump_flag_i ? {jump_addr_i[31:2], 2'b00} :
                 pred ? {bp_branch_addr_i[31:2], 2'b00} :
                 grant ? pc + 32'd4 : pc;
      head    <= flush ? '0 : head + QW'(deq);
      tail    <= flush ? '0 : tail + QW'(push);
      qcount  <= flush ? '0 : qcount + CW'(push) - CW'(deq);
      outst   <= outst_next;
      discard <= discard_next;
      a_wr    <= grant ? a_wr_nx : a_wr;
      a_rd    <= ibus_rvalid_i ? a_rd_nx : a_rd;
    end
  end

  // Storage: request addresses in flight and queued {addr,data} pairs
  always_ff @(posedge clk) begin
    if (grant) a_fifo[a_wr] <= pc;
    if (push) begin
      q_addr[tail] <= a_fifo[a_rd];
      q_data[tail] <= ibus_rdata_i;
    end
  end

  a_discard_le_outst: assert property (@(posedge clk) disable iff (!rst) discard <= outst);
  a_no_stray_rvalid:  assert property (@(posedge clk) disable iff (!rst) !(ibus_rvalid_i && outst == '0));
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed scenario tests for if_fetch_queue with a data=addr bus responder
module tb_if_fetch_queue;
  logic        clk, rst;
  logic        ibus_req_o, ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] ibus_addr_o, ibus_rdata_i;
  logic        inst_valid_o, id_ready_i, bp_isbranch_i, jump_flag_i;
  logic [31:0] inst_o, inst_addr_o, bp_branch_addr_i, jump_addr_i;
  int          checks = 0, errors = 0, ngnt = 0;
  logic        hold = 0;
  logic [31:0] pend [$];

  if_fetch_queue dut (
    .clk(clk), .rst(rst),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .id_ready_i(id_ready_i), .bp_isbranch_i(bp_isbranch_i), .bp_branch_addr_i(bp_branch_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    logic g, rv;
    logic [31:0] a;
    @(negedge clk);
    g = ibus_req_o && ibus_gnt_i;
    a = ibus_addr_o;
    rv = ibus_rvalid_i;
    @(posedge clk);
    #1;
    if (rv && pend.size() > 0) void'(pend.pop_front());
    if (g) begin
      pend.push_back(a);
      ngnt++;
    end
    ibus_rvalid_i = !hold && pend.size() > 0;
    ibus_rdata_i = pend.size() > 0 ? pend[0] : 32'h0;
  endtask

  task automatic do_reset();
    rst = 0;
    ibus_rvalid_i = 0;
    ibus_rdata_i = 0;
    pend.delete();
    hold = 0;
    jump_flag_i = 0;
    bp_isbranch_i = 0;
    ngnt = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    #1;
    checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", ibus_req_o); end
    checks++; if (ibus_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", ibus_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h13) begin errors++; $display("FAIL rst_inst got %h exp 00000013", inst_o); end
    checks++; if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL rst_iaddr got %h exp 0", inst_addr_o); end
  endtask

  task automatic test_stream();
    id_ready_i = 1;
    do_reset();
    tick();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", inst_valid_o); end
    checks++; if (ibus_addr_o !== 32'h4) begin errors++; $display("FAIL stream_pc got %h exp 4", ibus_addr_o); end
    for (int k = 2; k <= 7; k++) begin
      tick();
      checks++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * (k - 2)) || inst_o !== 32'(4 * (k - 2))) begin
        errors++;
        $display("FAIL stream_head%0d got v=%b a=%h d=%h exp v=1 a=d=%h", k, inst_valid_o, inst_addr_o, inst_o, 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_stall();
    id_ready_i = 0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    checks++; if (ngnt != 4) begin errors++; $display("FAIL stall_grants got %0d exp 4", ngnt); end
    checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", ibus_req_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin errors++; $display("FAIL stall_head got v=%b a=%h exp v=1 a=0", inst_valid_o, inst_addr_o); end
    id_ready_i = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stall_drain%0d got v=%b a=%h exp v=1 a=%h", k, inst_valid_o, inst_addr_o, 32'(4 * k));
      end
    end
  endtask

  task automatic test_predict();
    bit found = 0;
    id_ready_i = 1;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    id_ready_i = 0;
    hold = 1;
    ibus_rvalid_i = 0;
    tick();
    id_ready_i = 1;
    bp_isbranch_i = 1;
    bp_branch_addr_i = 32'h41;
    #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h10) begin errors++; $display("FAIL pred_head got v=%b a=%h exp v=1 a=10", inst_valid_o, inst_addr_o); end
    checks++; if (ibus_req_o !== 1'b0) begin errors++; $display("FAIL pred_two_outst_req got %b exp 0", ibus_req_o); end
    hold = 0;
    tick();
    bp_isbranch_i = 0;
    id_ready_i = 0;
    #1;
    checks++; if (ibus_addr_o !== 32'h40 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL pred_redirect got pc=%h v=%b exp pc=40 v=0", ibus_addr_o, inst_valid_o); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (inst_valid_o && !found) begin
        found = 1;
        checks++;
        if (inst_addr_o !== 32'h40 || inst_o !== 32'h40) begin errors++; $display("FAIL pred_target got a=%h d=%h exp a=d=40", inst_addr_o, inst_o); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL pred_timeout got no valid head exp head 40"); end
  endtask

  task automatic test_jump();
    id_ready_i = 0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    jump_flag_i = 1;
    jump_addr_i = 32'h103;
    #1;
    checks++; if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0) begin errors++; $display("FAIL jump_same_cycle got v=%b req=%b exp 0 0", inst_valid_o, ibus_req_o); end
    checks++; if (ibus_rvalid_i !== 1'b1) begin errors++; $display("FAIL jump_setup_rvalid got %b exp 1", ibus_rvalid_i); end
    tick();
    jump_flag_i = 0;
    #1;
    checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL jump_after got req=%b pc=%h v=%b exp 1 100 0", ibus_req_o, ibus_addr_o, inst_valid_o); end
    tick();
    tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== 32'h100) begin errors++; $display("FAIL jump_head got v=%b a=%h d=%h exp 1 100 100", inst_valid_o, inst_addr_o, inst_o); end
  endtask

  task automatic test_both();
    id_ready_i = 0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    id_ready_i = 1;
    bp_isbranch_i = 1;
    bp_branch_addr_i = 32'h40;
    jump_flag_i = 1;
    jump_addr_i = 32'h200;
    #1;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL both_nodeq got v=%b exp 0", inst_valid_o); end
    tick();
    jump_flag_i = 0;
    bp_isbranch_i = 0;
    id_ready_i = 0;
    #1;
    checks++; if (ibus_addr_o !== 32'h200) begin errors++; $display("FAIL both_pc got %h exp 200", ibus_addr_o); end
    tick();
    tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h200) begin errors++; $display("FAIL both_head got v=%b a=%h exp 1 200", inst_valid_o, inst_addr_o); end
  endtask

  task automatic test_wrap_reset();
    id_ready_i = 0;
    do_reset();
    tick();
    jump_flag_i = 1;
    jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_flag_i = 0;
    #1;
    checks++; if (ibus_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", ibus_addr_o); end
    tick();
    checks++; if (ibus_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", ibus_addr_o); end
    tick();
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head got v=%b d=%h exp 1 fffffffc", inst_valid_o, inst_o); end
    rst = 0;
    ibus_rvalid_i = 0;
    pend.delete();
    #1;
    checks++; if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_bus got req=%b pc=%h exp 0 0", ibus_req_o, ibus_addr_o); end
    checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || inst_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_head got v=%b d=%h a=%h exp 0 13 0", inst_valid_o, inst_o, inst_addr_o); end
    do_reset();
    tick();
  endtask

  initial begin
    ibus_gnt_i = 1;
    ibus_rvalid_i = 0;
    ibus_rdata_i = 0;
    id_ready_i = 0;
    bp_isbranch_i = 0;
    bp_branch_addr_i = 0;
    jump_flag_i = 0;
    jump_addr_i = 0;
    test_reset();
    test_stream();
    test_stall();
    test_predict();
    test_jump();
    test_both();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
